// File: rtl/alu_and_cmp_unit_if.sv
// Operation request / result bus for alu_and_cmp_unit.
// Latency: n/a (wires only); the slave registers results one cycle after in_valid.
// Backpressure: none; the slave accepts a request on every clock.
// Ports: master drives in_valid/op/a/b and observes out_valid/c/zero/sign;
//        slave observes the request and drives the result.
interface alu_and_cmp_unit_if #(
  parameter int WIDTH = 20
);
  logic             in_valid;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] c;
  logic             zero;
  logic             sign;

  modport master (
    output in_valid, op, a, b,
    input  out_valid, c, zero, sign
  );

  modport slave (
    input  in_valid, op, a, b,
    output out_valid, c, zero, sign
  );
endinterface

// File: rtl/alu_and_cmp_unit.sv
// Registered ALU slice: AND, equality and unsigned >= compare with zero/sign flags.
// Latency: 1 cycle from an accepted request (in_valid at edge N) to out_valid after edge N.
// Backpressure: none; one request accepted per clock, results never stall.
// Ports: clk (rising edge), rst (async, active-high), bus (slave modport):
//        in_valid/op/a/b request, out_valid/c/zero/sign registered result.
module alu_and_cmp_unit #(
  parameter int WIDTH = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_and_cmp_unit_if.slave     bus
);

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_EQ  = 2'b01;
  localparam logic [1:0] OP_GET = 2'b10;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_c;
  logic             r_zero;
  logic             r_sign;

  logic [WIDTH-1:0] w_and;
  logic             w_eq;
  logic             w_gt;
  logic [WIDTH-1:0] w_c;
  logic             w_zero;
  logic             w_sign;

  assign w_and = bus.a & bus.b;
  assign w_eq  = (bus.a == bus.b);
  // Operands are unsigned; the MSB carries magnitude, not sign.
  assign w_gt  = (bus.a > bus.b);

  always_comb begin
    w_c    = '0;
    w_zero = 1'b0;
    w_sign = 1'b0;
    case (bus.op)
      OP_AND: begin
        w_c    = w_and;
        w_zero = (w_and == '0);
        w_sign = w_and[WIDTH-1];
      end
      OP_EQ: begin
        w_zero = w_eq;
      end
      OP_GET: begin
        // zero/sign encode the three-way result; both low means a < b.
        w_zero = w_eq;
        w_sign = w_gt;
      end
      default: begin
        // NOP clears the flags but still produces a result pulse.
      end
    endcase
  end

  // Result fields only move on an accepted request so they hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_c         <= '0;
      r_zero      <= 1'b0;
      r_sign      <= 1'b0;
    end else begin
      r_out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_c    <= w_c;
        r_zero <= w_zero;
        r_sign <= w_sign;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.c         = r_c;
  assign bus.zero      = r_zero;
  assign bus.sign      = r_sign;

endmodule

// File: tb/tb_alu_and_cmp_unit.sv
module tb_alu_and_cmp_unit;
  localparam int W = 20;
  localparam logic [W-1:0] ONES = {W{1'b1}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Expected output state, maintained by the reference model.
  logic         ev;
  logic [W-1:0] ec;
  logic         ez;
  logic         es;

  logic [W+2:0] obs;
  logic [W+2:0] exp_v;

  alu_and_cmp_unit_if #(.WIDTH(W)) bus ();

  alu_and_cmp_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: results straight from the operation definitions.
  task automatic ref_model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] c, output logic z, output logic s);
    longint ua, ub;
    ua = longint'(a);
    ub = longint'(b);
    c = '0; z = 1'b0; s = 1'b0;
    if (op == 2'd0) begin
      c = a & b;
      z = (longint'(c) == 0);
      s = (longint'(c) >= (longint'(1) << (W - 1)));
    end else if (op == 2'd1) begin
      z = (ua == ub);
    end else if (op == 2'd2) begin
      z = (ua == ub);
      s = (ua > ub);
    end
  endtask

  // One clock: drive at negedge, let the edge happen, update the model, settle.
  task automatic cycle(input logic v, input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] c;
    logic z, s;
    @(negedge clk);
    bus.in_valid = v;
    bus.op       = op;
    bus.a        = a;
    bus.b        = b;
    @(posedge clk);
    if (v) begin
      ref_model(op, a, b, c, z, s);
      ev = 1'b1; ec = c; ez = z; es = s;
    end else begin
      ev = 1'b0;
    end
    #2;
    obs   = {bus.out_valid, bus.c, bus.zero, bus.sign};
    exp_v = {ev, ec, ez, es};
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    rst = 1'b1;
    #12;
    n_tests++;
    if ({bus.out_valid, bus.c, bus.zero, bus.sign} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got %h expected 0", {bus.out_valid, bus.c, bus.zero, bus.sign});
    end
    @(negedge clk); rst = 1'b0;
    ev = 1'b0; ec = '0; ez = 1'b0; es = 1'b0;
    // Produce a live result, then hit reset between edges while in_valid stays high.
    cycle(1'b1, 2'b00, ONES, ONES);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++; $display("FAIL reset_pre_result: got %h expected %h", obs, exp_v);
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if ({bus.out_valid, bus.c, bus.zero, bus.sign} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got %h expected 0", {bus.out_valid, bus.c, bus.zero, bus.sign});
    end
    @(posedge clk); #1;
    n_tests++;
    if ({bus.out_valid, bus.c, bus.zero, bus.sign} !== '0) begin
      n_fail++;
      $display("FAIL reset_discard: got %h expected 0", {bus.out_valid, bus.c, bus.zero, bus.sign});
    end
    @(negedge clk); rst = 1'b0; bus.in_valid = 1'b0;
    ev = 1'b0; ec = '0; ez = 1'b0; es = 1'b0;
    cycle(1'b1, 2'b00, 20'hFFFFF, 20'h0F0F0);
    n_tests++;
    if (obs !== {1'b1, 20'h0F0F0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_first_op: got %h expected %h", obs, {1'b1, 20'h0F0F0, 2'b00});
    end
  endtask

  task automatic test_and();
    cycle(1'b1, 2'b00, 20'hAAAAA, 20'h55555);
    n_tests++;
    if (obs !== {1'b1, 20'h00000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL and_zero: got %h expected %h", obs, {1'b1, 20'h00000, 2'b10});
    end
    cycle(1'b1, 2'b00, 20'h80001, 20'h80000);
    n_tests++;
    if (obs !== {1'b1, 20'h80000, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL and_sign: got %h expected %h", obs, {1'b1, 20'h80000, 2'b01});
    end
    cycle(1'b1, 2'b00, 20'h00000, 20'h00000);
    n_tests++;
    if (obs !== {1'b1, 20'h00000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL and_both_zero: got %h expected %h", obs, {1'b1, 20'h00000, 2'b10});
    end
  endtask

  task automatic test_eq();
    cycle(1'b1, 2'b01, 20'h12345, 20'h12345);
    n_tests++;
    if (obs !== {1'b1, 20'h00000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL eq_equal: got %h expected %h", obs, {1'b1, 20'h00000, 2'b10});
    end
    cycle(1'b1, 2'b01, 20'h12345, 20'h12344);
    n_tests++;
    if (obs !== {1'b1, 20'h00000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL eq_differ: got %h expected %h", obs, {1'b1, 20'h00000, 2'b00});
    end
    cycle(1'b1, 2'b01, 20'h00000, 20'h00000);
    n_tests++;
    if (obs !== {1'b1, 20'h00000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL eq_both_zero: got %h expected %h", obs, {1'b1, 20'h00000, 2'b10});
    end
  endtask

  task automatic test_get();
    cycle(1'b1, 2'b10, 20'h00010, 20'h00010);
    n_tests++;
    if (obs !== {1'b1, 20'h00000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL get_equal: got %h expected %h", obs, {1'b1, 20'h00000, 2'b10});
    end
    cycle(1'b1, 2'b10, 20'hFFFFF, 20'h00000);
    n_tests++;
    if (obs !== {1'b1, 20'h00000, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL get_greater: got %h expected %h", obs, {1'b1, 20'h00000, 2'b01});
    end
    cycle(1'b1, 2'b10, 20'h00001, 20'h80000);
    n_tests++;
    if (obs !== {1'b1, 20'h00000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL get_less_unsigned: got %h expected %h", obs, {1'b1, 20'h00000, 2'b00});
    end
    cycle(1'b1, 2'b10, 20'h00000, 20'h00000);
    n_tests++;
    if (obs !== {1'b1, 20'h00000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL get_both_zero: got %h expected %h", obs, {1'b1, 20'h00000, 2'b10});
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 2'b00, 20'hF00FF, 20'hFF0F0);
    n_tests++;
    if (obs !== {1'b1, 20'hF00F0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL b2b_and: got %h expected %h", obs, {1'b1, 20'hF00F0, 2'b01});
    end
    cycle(1'b1, 2'b01, 20'h00077, 20'h00077);
    n_tests++;
    if (obs !== {1'b1, 20'h00000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL b2b_eq: got %h expected %h", obs, {1'b1, 20'h00000, 2'b10});
    end
    cycle(1'b1, 2'b10, 20'h90000, 20'h10000);
    n_tests++;
    if (obs !== {1'b1, 20'h00000, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL b2b_get: got %h expected %h", obs, {1'b1, 20'h00000, 2'b01});
    end
    // Idle cycles with junk inputs: valid drops, GET result holds.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 2'(i), 20'(($urandom)), 20'h00000);
      n_tests++;
      if (obs !== {1'b0, 20'h00000, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL b2b_hold%0d: got %h expected %h", i, obs, {1'b0, 20'h00000, 2'b01});
      end
    end
  endtask

  task automatic test_nop();
    cycle(1'b1, 2'b01, 20'h00ABC, 20'h00ABC);
    n_tests++;
    if (obs !== {1'b1, 20'h00000, 1'b1, 1'b0}) begin
      n_fail++; $display("FAIL nop_setup: got %h expected %h", obs, {1'b1, 20'h00000, 2'b10});
    end
    cycle(1'b1, 2'b11, 20'hFFFFF, 20'hFFFFF);
    n_tests++;
    if (obs !== {1'b1, 20'h00000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL nop_clear: got %h expected %h", obs, {1'b1, 20'h00000, 2'b00});
    end
  endtask

  task automatic test_random();
    logic         v;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 400; i++) begin
      v  = ($urandom_range(0, 3) != 0);
      op = 2'($urandom_range(0, 3));
      a  = W'($urandom);
      case ($urandom_range(0, 4))
        0:       b = a;
        1:       b = a ^ (W'(1) << $urandom_range(0, W - 1));
        default: b = W'($urandom);
      endcase
      cycle(v, op, a, b);
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random[%0d] v=%0b op=%0d a=%h b=%h: got %h expected %h", i, v, op, a, b, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_eq();
    test_get();
    test_back_to_back();
    test_nop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
